rf_recovery_ctrl: RTL and testbench

RF_RECOVERY_CTRL -- requirements
Module: rf_recovery_ctrl

---
 rtl/ft_pkg.sv | 21 ++
 rtl/shadow_regfile.sv | 35 +++
 rtl/rf_recovery_ctrl.sv | 127 ++++++++++++
 tb/tb_rf_recovery_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: recovery FSM states and register-file sizing.
package ft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HALT    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } rec_state_e;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 1 << DEF_ADDR_WIDTH;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Number of architectural registers for a given address width.
    function automatic int reg_count(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/shadow_regfile.sv
// Last-known-good register copy: one synchronous write port, one combinational
// read port; entry 0 is architecturally zero and never written.
module shadow_regfile
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int NREG = reg_count(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [NREG];

    // Clear all entries on reset; commit writes to non-zero addresses only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i == '0) ? '0 : mem[raddr_i];

endmodule

// File: rtl/rf_recovery_ctrl.sv
// Lockstep register-file recovery: shadows agreed writes and, on a comparator
// mismatch, halts both cores, drains, then replays every shadow register.
module rf_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  error_i,
    output logic                  halt_o,
    output logic                  rec_we_o,
    output logic [ADDR_WIDTH-1:0] rec_addr_o,
    output logic [DATA_WIDTH-1:0] rec_data_o,
    output logic                  done_o,
    output logic [7:0]            err_cnt_o
);

    localparam int                    NREG       = reg_count(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NREG - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [3:0]            DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    rec_state_e            state_q;
    rec_state_e            state_d;
    logic [3:0]            drain_q;
    logic [ADDR_WIDTH-1:0] rcnt_q;
    logic [7:0]            err_cnt_q;
    logic                  start;
    logic                  commit;
    logic [DATA_WIDTH-1:0] shadow_rdata;

    // A mismatch seen while idle both starts recovery and vetoes that cycle's write.
    assign start  = (state_q == ST_IDLE) && error_i;
    assign commit = (state_q == ST_IDLE) && we_i && !error_i && (addr_i != '0);

    shadow_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (commit),
        .waddr_i (addr_i),
        .wdata_i (data_i),
        .raddr_i (rcnt_q),
        .rdata_o (shadow_rdata)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: drain, replay registers 1..last, then a single done cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (error_i) state_d = ST_HALT;
            ST_HALT:    if (drain_q == DRAIN_LAST) state_d = ST_RESTORE;
            ST_RESTORE: if (rcnt_q == LAST_ADDR) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Drain timer and restore address counter; the counter is re-armed to 1 outside RESTORE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_q <= '0;
            rcnt_q  <= FIRST_ADDR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drain_q <= '0;
                    rcnt_q  <= FIRST_ADDR;
                end
                ST_HALT: begin
                    drain_q <= drain_q + 4'd1;
                    rcnt_q  <= FIRST_ADDR;
                end
                ST_RESTORE: begin
                    rcnt_q <= rcnt_q + FIRST_ADDR;
                end
                default: begin
                    drain_q <= '0;
                    rcnt_q  <= FIRST_ADDR;
                end
            endcase
        end
    end

    // Saturating count of recoveries started.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (start && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Outputs decoded from state; restore bus is held at zero outside RESTORE.
    always_comb begin
        halt_o     = (state_q != ST_IDLE);
        rec_we_o   = 1'b0;
        rec_addr_o = '0;
        rec_data_o = '0;
        done_o     = (state_q == ST_DONE);
        if (state_q == ST_RESTORE) begin
            rec_we_o   = 1'b1;
            rec_addr_o = rcnt_q;
            rec_data_o = shadow_rdata;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_rf_recovery_ctrl.sv
// Bench for rf_recovery_ctrl: cycle-level reference model plus directed scenarios.
module tb_rf_recovery_ctrl;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int DRAIN    = 2;
    localparam int NREG     = 32;
    localparam int HALT_LEN = DRAIN + NREG;

    logic          clk     = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          we_i    = 1'b0;
    logic [AW-1:0] addr_i  = '0;
    logic [DW-1:0] data_i  = '0;
    logic          error_i = 1'b0;
    logic          halt_o;
    logic          rec_we_o;
    logic [AW-1:0] rec_addr_o;
    logic [DW-1:0] rec_data_o;
    logic          done_o;
    logic [7:0]    err_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_recovery_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .error_i    (error_i),
        .halt_o     (halt_o),
        .rec_we_o   (rec_we_o),
        .rec_addr_o (rec_addr_o),
        .rec_data_o (rec_data_o),
        .done_o     (done_o),
        .err_cnt_o  (err_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since a recovery began (0 = idle).
    logic [DW-1:0] m_shadow [NREG];
    int            m_t   = 0;
    int            m_cnt = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) m_shadow[i] <= '0;
            m_t   <= 0;
            m_cnt <= 0;
        end else if (m_t == 0) begin
            if (error_i) begin
                m_t <= 1;
                if (m_cnt < 255) m_cnt <= m_cnt + 1;
            end else if (we_i && (addr_i != '0)) begin
                m_shadow[addr_i] <= data_i;
            end
        end else if (m_t == HALT_LEN) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic          ewe;
        int            ea;
        logic [DW-1:0] ed;
        ewe = (m_t > DRAIN) && (m_t <= DRAIN + NREG - 1);
        ea  = ewe ? (m_t - DRAIN) : 0;
        ed  = ewe ? m_shadow[ea] : '0;
        chk("halt",     64'(halt_o),     64'(m_t != 0));
        chk("rec_we",   64'(rec_we_o),   64'(ewe));
        chk("rec_addr", 64'(rec_addr_o), 64'(ea));
        chk("rec_data", 64'(rec_data_o), 64'(ed));
        chk("done",     64'(done_o),     64'(m_t == HALT_LEN));
        chk("err_cnt",  64'(err_cnt_o),  64'(m_cnt));
    end

    // Capture of one recovery window.
    logic [DW-1:0] cap  [NREG];
    bit            seen [NREG];
    int            cap_halt, cap_we, cap_done, cap_done_at;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse error_i for one cycle (alongside whatever write is presented) and record the window.
    task automatic recover();
        int nexp;
        for (int i = 0; i < NREG; i++) begin
            cap[i]  = '0;
            seen[i] = 1'b0;
        end
        cap_halt = 0; cap_we = 0; cap_done = 0; cap_done_at = 0; nexp = 1;
        error_i = 1'b1;
        step();
        error_i = 1'b0;
        we_i    = 1'b0;
        repeat (HALT_LEN + 6) begin
            @(negedge clk);
            if (halt_o) cap_halt++;
            if (rec_we_o) begin
                cap_we++;
                chk("restore_addr_seq", 64'(rec_addr_o), 64'(nexp));
                nexp++;
                cap[rec_addr_o]  = rec_data_o;
                seen[rec_addr_o] = 1'b1;
            end
            if (done_o) begin
                cap_done++;
                cap_done_at = cap_halt;
            end
        end
        step();
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_i = 1'b1; addr_i = a; data_i = d;
        step();
        we_i = 1'b0;
    endtask

    initial begin
        int  nz;
        bit  found;

        // Reset state
        step(); step();
        chk("reset_halt",    64'(halt_o),    64'd0);
        chk("reset_rec_we",  64'(rec_we_o),  64'd0);
        chk("reset_done",    64'(done_o),    64'd0);
        chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // Commit, boundary address, and recovery timing
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd31, 32'hA5A5A5A5);
        recover();
        chk("commit_addr5",  64'(cap[5]),      64'hDEADBEEF);
        chk("commit_addr31", 64'(cap[31]),     64'hA5A5A5A5);
        chk("halt_cycles",   64'(cap_halt),    64'd34);
        chk("restore_cycles",64'(cap_we),      64'd31);
        chk("done_pulses",   64'(cap_done),    64'd1);
        chk("done_last_halt",64'(cap_done_at), 64'd34);
        chk("no_restore_a0", 64'(seen[0]),     64'd0);
        chk("err_cnt_1",     64'(err_cnt_o),   64'd1);

        // Write blocked by a simultaneous mismatch
        write_reg(5'd7, 32'h11);
        we_i = 1'b1; addr_i = 5'd7; data_i = 32'h22;
        recover();
        chk("blocked_addr7", 64'(cap[7]),    64'h11);
        chk("err_cnt_2",     64'(err_cnt_o), 64'd2);

        // Address 0 is never written or restored
        write_reg(5'd0, 32'hFFFFFFFF);
        recover();
        chk("a0_no_restore", 64'(seen[0]),  64'd0);
        chk("a0_no_alias",   64'(cap[5]),   64'hDEADBEEF);
        chk("a0_restore_n",  64'(cap_we),   64'd31);

        // error_i held high through DONE restarts on the first idle cycle
        error_i = 1'b1;
        repeat (HALT_LEN + 3) step();
        error_i = 1'b0;
        repeat (HALT_LEN + 6) step();
        chk("held_err_cnt",  64'(err_cnt_o), 64'd5);

        // Reset in the middle of RESTORE
        write_reg(5'd10, 32'h1234);
        error_i = 1'b1;
        step();
        error_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rec_we_o && rec_addr_o == 5'd10) found = 1'b1;
        end
        chk("wait_addr10", 64'(found), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_halt",    64'(halt_o),     64'd0);
        chk("midrst_rec_we",  64'(rec_we_o),   64'd0);
        chk("midrst_addr",    64'(rec_addr_o), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt_o),  64'd0);
        step(); step();
        rst_ni = 1'b1;
        step();
        recover();
        nz = 0;
        for (int i = 0; i < NREG; i++) if (cap[i] != '0) nz++;
        chk("shadow_cleared", 64'(nz),        64'd0);
        chk("post_rst_cnt",   64'(err_cnt_o), 64'd1);

        // Saturation of the recovery counter
        repeat (256) begin
            error_i = 1'b1;
            step();
            error_i = 1'b0;
            repeat (HALT_LEN + 1) step();
        end
        chk("sat_255",  64'(err_cnt_o), 64'd255);
        recover();
        chk("sat_hold", 64'(err_cnt_o), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
